// File: rtl/ysyx_23060025_icache_pkg.sv
// ysyx_23060025_icache_pkg: shared state encoding, geometry helpers and AXI size constant for the associative icache
package ysyx_23060025_icache_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, AR, R, FILL, RESP, FLUSH} state_t;
  localparam logic [2:0] ARSIZE_WORD = 3'b010;
  function automatic int beats(input int line_off_w);
    return (1 << line_off_w) / 4;
  endfunction
  function automatic int tag_w(input int addr_w, input int set_w, input int line_off_w);
    return addr_w - set_w - line_off_w;
  endfunction
  function automatic int ptr_w(input int ways);
    return ways > 1 ? $clog2(ways) : 1;
  endfunction
  function automatic int cnt_w(input int n_beats);
    return n_beats > 1 ? $clog2(n_beats) : 1;
  endfunction
endpackage

// File: rtl/ysyx_23060025_icache_way.sv
// ysyx_23060025_icache_way: one way's data/tag/valid storage (set_idx/tag/word_idx in, word/tag/valid writes, flush; hit/valid/word out)
module ysyx_23060025_icache_way #(
  parameter int TAG_W  = 24,
  parameter int SET_W  = 4,
  parameter int WORD_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [SET_W-1:0]  set_idx,
  input  logic [TAG_W-1:0]  tag,
  input  logic [WORD_W-1:0] word_idx,
  input  logic              word_we,
  input  logic [31:0]       wdata,
  input  logic              tag_we,
  input  logic              valid_set,
  input  logic              flush,
  output logic              hit,
  output logic              valid,
  output logic [31:0]       word
);
  logic [31:0]       data [2**SET_W][2**WORD_W];
  logic [TAG_W-1:0]  tags [2**SET_W];
  logic [2**SET_W-1:0] valids;
  always_ff @(posedge clock) begin
    if (word_we) data[set_idx][word_idx] <= wdata;
    if (tag_we) tags[set_idx] <= tag;
  end
  always_ff @(posedge clock)
    if (reset || flush) valids <= '0;
    else if (valid_set) valids[set_idx] <= 1'b1;
  assign valid = valids[set_idx];
  assign hit   = valid && tags[set_idx] == tag;
  assign word  = data[set_idx][word_idx];
endmodule

// File: rtl/ysyx_23060025_icache_assoc.sv
// ysyx_23060025_icache_assoc: N-way set-associative icache between IFU (psel/pready) and AXI-lite burst refill, with fence.i and perf pulses
module ysyx_23060025_icache_assoc
  import ysyx_23060025_icache_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int WAYS            = 2,
  parameter int SET_ADDR_W      = 4,
  parameter int LINE_OFF_ADDR_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] in_paddr,
  input  logic                  in_psel,
  output logic                  in_pready,
  output logic [DATA_WIDTH-1:0] in_prdata,
  input  logic                  fence_i,
  output logic [ADDR_WIDTH-1:0] out_araddr,
  output logic                  out_arvalid,
  input  logic                  out_arready,
  output logic [7:0]            out_arlen,
  output logic [2:0]            out_arsize,
  input  logic                  out_rvalid,
  input  logic [DATA_WIDTH-1:0] out_rdata,
  input  logic                  out_rlast,
  output logic                  out_rready,
  output logic                  perf_hit,
  output logic                  perf_miss
);
  localparam int BEATS  = beats(LINE_OFF_ADDR_W);
  localparam int TAG_W  = tag_w(ADDR_WIDTH, SET_ADDR_W, LINE_OFF_ADDR_W);
  localparam int PTR_W  = ptr_w(WAYS);
  localparam int CNT_W  = cnt_w(BEATS);
  localparam int SETS   = 2**SET_ADDR_W;
  state_t                 state;
  logic                   pending;
  logic [PTR_W-1:0]       victim, pick;
  logic [PTR_W-1:0]       rr [SETS];
  logic [CNT_W-1:0]       cnt;
  logic [WAYS-1:0]        hits, valids;
  logic [31:0]            words [WAYS];
  logic [31:0]            hit_word;
  logic [TAG_W-1:0]       tag;
  logic [SET_ADDR_W-1:0]  set;
  logic [CNT_W-1:0]       word, word_idx;
  logic                   unused;
  assign tag      = in_paddr[ADDR_WIDTH-1 -: TAG_W];
  assign set      = in_paddr[LINE_OFF_ADDR_W +: SET_ADDR_W];
  assign word     = in_paddr[LINE_OFF_ADDR_W-1:2];
  assign word_idx = state == R ? cnt : word;
  assign unused   = ^{out_rlast, in_paddr[1:0]};
  assign out_araddr = out_arvalid ? {in_paddr[ADDR_WIDTH-1:LINE_OFF_ADDR_W], LINE_OFF_ADDR_W'(0)} : '0;
  assign out_arlen  = out_arvalid ? 8'(BEATS-1) : '0;
  assign out_arsize = out_arvalid ? ARSIZE_WORD : '0;
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    ysyx_23060025_icache_way #(.TAG_W(TAG_W), .SET_W(SET_ADDR_W), .WORD_W(CNT_W)) u_way (
      .clock    (clock),
      .reset    (reset),
      .set_idx  (set),
      .tag      (tag),
      .word_idx (word_idx),
      .word_we  (state == R && out_rvalid && victim == PTR_W'(w)),
      .wdata    (out_rdata),
      .tag_we   (state == FILL && victim == PTR_W'(w)),
      .valid_set(state == FILL && victim == PTR_W'(w)),
      .flush    (state == FLUSH),
      .hit      (hits[w]),
      .valid    (valids[w]),
      .word     (words[w])
    );
  end
  always_comb begin
    hit_word = '0;
    pick = rr[set];
    for (int i = WAYS-1; i >= 0; i--) begin
      hit_word = hit_word | (hits[i] ? words[i] : '0);
      pick = valids[i] ? pick : PTR_W'(i);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= 1'b0;
      victim      <= '0;
      cnt         <= '0;
      in_pready   <= 1'b0;
      in_prdata   <= '0;
      out_arvalid <= 1'b0;
      out_rready  <= 1'b0;
      perf_hit    <= 1'b0;
      perf_miss   <= 1'b0;
      for (int i = 0; i < SETS; i++) rr[i] <= '0;
    end else begin
      if (fence_i && state != IDLE) pending <= 1'b1;
      case (state)
        IDLE: state <= (fence_i || pending) ? FLUSH : in_psel ? LOOKUP : IDLE;
        LOOKUP: begin
          victim <= pick;
          if (|hits) begin
            state     <= RESP;
            in_pready <= 1'b1;
            in_prdata <= hit_word;
            perf_hit  <= 1'b1;
          end else begin
            state       <= AR;
            out_arvalid <= 1'b1;
            perf_miss   <= 1'b1;
          end
        end
        AR: begin
          perf_miss <= 1'b0;
          if (out_arready) begin
            out_arvalid <= 1'b0;
            out_rready  <= 1'b1;
            state       <= R;
          end
        end
        R: if (out_rvalid) begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(BEATS-1)) begin
            out_rready <= 1'b0;
            state      <= FILL;
          end
        end
        FILL: begin
          cnt       <= '0;
          rr[set]   <= rr[set] == PTR_W'(WAYS-1) ? '0 : rr[set] + 1'b1;
          in_pready <= 1'b1;
          in_prdata <= words[victim];
          state     <= RESP;
        end
        RESP: begin
          in_pready <= 1'b0;
          in_prdata <= '0;
          perf_hit  <= 1'b0;
          state     <= IDLE;
        end
        FLUSH: begin
          pending <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ysyx_23060025_icache_assoc.md
Name: ysyx_23060025_icache_assoc

Overview:
Parametrised N-way set-associative instruction cache. It is the successor of the direct-mapped icache and sits between the IFU (APB-like psel/pready request) and the AXI-lite read channel to DRAM. It adds:
- valid bits per line
- one-transaction burst line refill
- per-set round-robin replacement
- fence.i whole-cache invalidate
- hit/miss performance pulses

Parameters:
ADDR_WIDTH, 32, physical address width
DATA_WIDTH, 32, fetch word width (fixed at 32 in this generation)
WAYS, 2, associativity; power of two, 1..4
SET_ADDR_W, 4, log2(number of sets)
LINE_OFF_ADDR_W, 4, log2(line bytes); line = 2^LINE_OFF_ADDR_W bytes, BEATS = 2^LINE_OFF_ADDR_W/4 (>=2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
in_paddr  in  ADDR_WIDTH  fetch address; bits[1:0] ignored
in_psel  in  1  fetch request
in_pready  out  1  one-cycle response pulse
in_prdata  out  32  fetched instruction; valid while in_pready=1, else 0
fence_i  in  1  invalidate-all request (level, sampled)
out_araddr  out  ADDR_WIDTH  line-aligned refill address
out_arvalid  out  1  read-address valid
out_arready  in  1  read-address ready
out_arlen  out  8  BEATS-1
out_arsize  out  3  3'b010
out_rvalid  in  1  read-data valid
out_rdata  in  32  read data beat
out_rlast  in  1  last beat marker
out_rready  out  1  read-data ready
perf_hit  out  1  one-cycle pulse per hit
perf_miss  out  1  one-cycle pulse per miss

Behaviour:
- Clock is clock. Reset is synchronous, active-high.
- Reset effects:
  - state=IDLE; all valid bits, victim pointers and beat counter cleared
  - all outputs 0
  - tag/data arrays need no reset
  - reset mid-refill abandons the burst immediately (rready=0); the interconnect is reset in the same cycle
- Address split: tag = [ADDR_WIDTH-1 : SET_ADDR_W+LINE_OFF_ADDR_W]; set = next SET_ADDR_W bits; word = [LINE_OFF_ADDR_W-1:2].
- The IFU holds in_paddr and in_psel stable from psel until pready.
- States: IDLE, LOOKUP, AR, R, FILL, RESP, FLUSH.
- IDLE:
  - fence_i, or a pending fence → FLUSH (fence wins over a simultaneous psel)
  - else psel → LOOKUP
- LOOKUP:
  - hit = any way with valid && tag match; at most one way may match
  - hit → RESP, perf_hit=1
  - miss → AR, perf_miss=1
- Victim selection: lowest-index invalid way; if all ways valid, the set's round-robin pointer.
- AR:
  - out_arvalid=1, araddr = {tag, set, 0}, arlen=BEATS-1, arsize=2
  - stay until arready; then arvalid=0 next cycle → R
- R:
  - rready=1
  - each rvalid writes out_rdata into victim line word[beat] and increments the beat counter
  - on the beat where counter==BEATS-1 → FILL
  - rlast is not used for control; a bench assertion checks rlast==(counter==BEATS-1) on every rvalid beat
- FILL:
  - write tag, set valid, advance the set's round-robin pointer (mod WAYS), clear the beat counter → RESP
- RESP:
  - in_pready=1 for exactly one cycle; in_prdata = selected word → IDLE
- FLUSH:
  - clear all valid bits in one cycle, clear the pending flag → IDLE
- fence_i asserted outside IDLE sets a pending flag. The current request completes with the pre-fence contents; the flush happens before the next lookup.
- Latency:
  - hit: psel cycle t → pready at t+2
  - miss: ≥ t+4+BEATS, plus bus wait states
- Back-to-back requests: psel held high in the IDLE cycle after pready starts a new lookup (one idle cycle between requests).

Decomposition:
- Package ysyx_23060025_icache_pkg:
  - state encodings
  - functions computing BEATS, TAG_W and the width of the victim pointer and beat counter
  - ARSIZE_WORD constant
- Sub-module ysyx_23060025_icache_way: one way's data/tag/valid storage.
  - Inputs: set index, word write enable and word index, tag write, valid set, flush.
  - Outputs: hit, line word.
  - Instantiated WAYS times with a generate loop.

Test Plan:
- Cold miss at 0x8000_0000 (defaults): arvalid with araddr 0x8000_0000, arlen=3, arsize=2; 4 beats 0x11,0x22,0x33,0x44 → pready once, prdata=0x11, perf_miss=1.
- Refetch 0x8000_0008 after the cold-miss fill → pready two cycles after psel, prdata=0x33, perf_hit=1, no arvalid.
- Conflict fills 0x8000_0000, 0x8000_0100, 0x8000_0200 (same set, WAYS=2): third fill evicts the first line; refetch of 0x8000_0100 hits, refetch of 0x8000_0000 misses.
- fence_i pulsed during the R state of a miss → that fetch returns fill data; the next fetch of the same address misses (arvalid seen).
- arready held low 5 cycles, then rvalid with 2-cycle gaps between beats → arvalid stable until handshake, data correct, rlast assertion holds.
- Reset asserted during the second refill beat → next cycle all outputs 0; the following fetch of the same address misses.
